// File: rtl/ycbcr_block_scheduler_pkg.sv
// Shared types and constants for the YCbCr block scheduler: component tags,
// read-FSM states and the default block size.
package ycbcr_block_scheduler_pkg;

  localparam int BLOCK_SAMPLES = 64;
  localparam int NUM_COMP      = 3;

  typedef enum logic [1:0] {
    COMP_Y  = 2'd0,
    COMP_CB = 2'd1,
    COMP_CR = 2'd2
  } comp_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_Y,
    SEND_CB,
    SEND_CR
  } sched_state_t;

  function automatic comp_t state_comp(input sched_state_t s);
    case (s)
      SEND_CB: return COMP_CB;
      SEND_CR: return COMP_CR;
      default: return COMP_Y;
    endcase
  endfunction

endpackage

// File: rtl/ycbcr_block_scheduler_block_bank.sv
// One ping-pong bank: 3 component planes of BLOCK_SAMPLES samples each, with a
// triple write port and a single combinational read port.
module ycbcr_block_scheduler_block_bank
  import ycbcr_block_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int BLOCK_SAMPLES = ycbcr_block_scheduler_pkg::BLOCK_SAMPLES,
  parameter int IDX_W         = $clog2(BLOCK_SAMPLES)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i [NUM_COMP],
  input  comp_t                 rd_comp_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_COMP][BLOCK_SAMPLES];

  // NOTE: sample storage has no reset; the full flags decide what is valid,
  // so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int c = 0; c < NUM_COMP; c++) begin
        mem_q[c][wr_idx_i] <= wr_data_i[c];
      end
    end
  end

  always_comb begin
    case (rd_comp_i)
      COMP_CB: rd_data_o = mem_q[1][rd_idx_i];
      COMP_CR: rd_data_o = mem_q[2][rd_idx_i];
      default: rd_data_o = mem_q[0][rd_idx_i];
    endcase
  end

endmodule

// File: rtl/ycbcr_block_scheduler.sv
// Collects 8x8 blocks of YCbCr triples into two banks and streams each block
// to the DCT as back-to-back Y, Cb, Cr planes under valid/ready.
module ycbcr_block_scheduler
  import ycbcr_block_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH    = 10,
  parameter int BLOCK_SAMPLES = ycbcr_block_scheduler_pkg::BLOCK_SAMPLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data [NUM_COMP],
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_comp,
  output logic                  out_sob,
  output logic                  out_eob,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int               IDX_W    = $clog2(BLOCK_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SAMPLES - 1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  sched_state_t     state_q, state_d;

  logic             wr_fire, wr_done, rd_done;
  comp_t            rd_comp;
  logic [DATA_WIDTH-1:0] bank_rd_data [2];

  // in_ready depends only on registered flags, never on in_valid.
  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign wr_done  = wr_fire && (wr_idx_q == LAST_IDX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ycbcr_block_scheduler_block_bank #(
      .DATA_WIDTH    (DATA_WIDTH),
      .BLOCK_SAMPLES (BLOCK_SAMPLES)
    ) u_bank (
      .clk       (clk),
      .we_i      (wr_fire && (wr_bank_q == 1'(b))),
      .wr_idx_i  (wr_idx_q),
      .wr_data_i (in_data),
      .rd_comp_i (rd_comp),
      .rd_idx_i  (rd_idx_q),
      .rd_data_o (bank_rd_data[b])
    );
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    rd_done   = 1'b0;
    out_valid = 1'b0;
    rd_comp   = COMP_Y;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) state_d = SEND_Y;
      end
      SEND_Y, SEND_CB, SEND_CR: begin
        out_valid = 1'b1;
        rd_comp   = state_comp(state_q);
        if (out_ready) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            case (state_q)
              SEND_Y:  state_d = SEND_CB;
              SEND_CB: state_d = SEND_CR;
              default: begin
                // Chain straight into the other bank if it is already waiting.
                rd_done   = 1'b1;
                rd_bank_d = ~rd_bank_q;
                state_d   = full_q[~rd_bank_q] ? SEND_Y : IDLE;
              end
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    full_d    = full_q;
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    // The writer never targets a full bank, so set and clear cannot collide.
    if (rd_done) full_d[rd_bank_q] = 1'b0;
  end

  assign out_comp = rd_comp;
  assign out_data = out_valid ? bank_rd_data[rd_bank_q] : '0;
  assign out_sob  = out_valid && (rd_idx_q == '0);
  assign out_eob  = out_valid && (rd_idx_q == LAST_IDX);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      state_q   <= IDLE;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: tb/tb_ycbcr_block_scheduler.sv
// Directed bench for ycbcr_block_scheduler: single block, back-pressure,
// output stall, coincident write/read completion and mid-stream async reset.
module tb_ycbcr_block_scheduler;

  localparam int DW  = 10;
  localparam int BS  = 64;
  localparam int BLK = 3 * BS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] in_data [3];
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready, out_sob, out_eob, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_comp;
  logic [DW+3:0] obs;
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  assign obs = {out_comp, out_sob, out_eob, out_data};

  ycbcr_block_scheduler #(.DATA_WIDTH(DW), .BLOCK_SAMPLES(BS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_comp  (out_comp),
    .out_sob   (out_sob),
    .out_eob   (out_eob),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Stimulus pattern: Y=off+k, Cb=off+100+k, Cr=off+200+k.
  task automatic set_pixel(input int off, input int k);
    in_data[0] = DW'(off + k);
    in_data[1] = DW'(off + 100 + k);
    in_data[2] = DW'(off + 200 + k);
  endtask

  // Expected {comp, sob, eob, data} for the n-th output of a block.
  function automatic logic [DW+3:0] exp_out(input int off, input int n);
    int            c  = n / BS;
    int            k  = n % BS;
    logic [1:0]    cv = 2'(c);
    logic [DW-1:0] dv = DW'(off + c * 100 + k);
    return {cv, (k == 0), (k == BS - 1), dv};
  endfunction

  task automatic test_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_pixel(0, 0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({out_valid, obs} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b obs=%h expected all 0", out_valid, obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_after_reset: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_block(input int off);
    int acc = 0, outs = 0, t64 = -1, first = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_pixel(off, 0);
    for (int cyc = 0; cyc < 600 && outs < BLK; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        if (first < 0) first = cyc;
        checks++;
        if (obs !== exp_out(off, outs)) begin
          failures++;
          $display("FAIL single_sample[%0d] off=%0d: got %h expected %h", outs, off, obs, exp_out(off, outs));
        end
        outs++;
      end
      if (in_valid && in_ready) begin
        acc++;
        if (acc == BS) t64 = cyc;
      end
      @(posedge clk); #1;
      if (acc >= BS) in_valid = 1'b0;
      else set_pixel(off, acc);
    end
    checks++;
    if (outs != BLK) begin
      failures++;
      $display("FAIL single_count off=%0d: got %0d expected %0d", off, outs, BLK);
    end
    checks++;
    if (first != t64 + 2) begin
      failures++;
      $display("FAIL single_latency off=%0d: got cycle %0d expected %0d", off, first, t64 + 2);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_idle_after off=%0d: got valid=%b ready=%b expected 0/1", off, out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure_fill();
    int acc = 0, outs = 0, gaps = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_pixel(300, 0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      set_pixel((acc < BS) ? 300 : 600, acc % BS);
    end
    checks++;
    if (acc != 2 * BS || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_fill: got accepts=%0d ready=%b expected %0d/0", acc, in_ready, 2 * BS);
    end
    checks++;
    if (out_valid !== 1'b1 || obs !== exp_out(300, 0)) begin
      failures++;
      $display("FAIL bp_held_first: got valid=%b obs=%h expected 1/%h", out_valid, obs, exp_out(300, 0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 1000 && outs < 2 * BLK; cyc++) begin
      @(negedge clk);
      if (outs == BLK - 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_before_free: got %b expected 0", in_ready);
        end
      end
      if (outs == BLK) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL bp_ready_after_free: got %b expected 1", in_ready);
        end
      end
      if (out_valid) begin
        checks++;
        if (obs !== exp_out((outs < BLK) ? 300 : 600, outs % BLK)) begin
          failures++;
          $display("FAIL bp_sample[%0d]: got %h expected %h", outs, obs, exp_out((outs < BLK) ? 300 : 600, outs % BLK));
        end
        outs++;
      end else if (outs > 0) begin
        gaps++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (outs != 2 * BLK || gaps != 0) begin
      failures++;
      $display("FAIL bp_stream: got outputs=%0d gaps=%0d expected %0d/0", outs, gaps, 2 * BLK);
    end
  endtask

  task automatic test_output_stall();
    int            acc = 0, outs = 0;
    logic          prev_stall = 1'b0;
    logic [DW+3:0] prev_obs = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_pixel(50, 0);
    for (int cyc = 0; cyc < 2000 && outs < BLK; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          failures++;
          $display("FAIL stall_hold[%0d]: got valid=%b obs=%h expected 1/%h", outs, out_valid, obs, prev_obs);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (obs !== exp_out(50, outs)) begin
          failures++;
          $display("FAIL stall_sample[%0d]: got %h expected %h", outs, obs, exp_out(50, outs));
        end
        outs++;
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = obs;
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
      if (acc >= BS) in_valid = 1'b0;
      else set_pixel(50, acc);
      out_ready = (outs >= BS && outs < 2 * BS) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    out_ready = 1'b1;
    checks++;
    if (outs != BLK) begin
      failures++;
      $display("FAIL stall_count: got %0d expected %0d", outs, BLK);
    end
  endtask

  task automatic test_simultaneous();
    int   acc = 0, outs = 0, t_last = -1, t_b = -1, first_b = -1;
    logic gap_valid = 1'bx, gap_ready = 1'bx;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_pixel(20, 0);
    for (int cyc = 0; cyc < 1500 && outs < 2 * BLK; cyc++) begin
      @(negedge clk);
      if (t_b >= 0 && cyc == t_b + 1) begin
        gap_valid = out_valid;
        gap_ready = in_ready;
      end
      if (out_valid) begin
        if (outs == BLK && first_b < 0) first_b = cyc;
        if (outs == BLK - 1) t_last = cyc;
        checks++;
        if (obs !== exp_out((outs < BLK) ? 20 : 400, outs % BLK)) begin
          failures++;
          $display("FAIL simul_sample[%0d]: got %h expected %h", outs, obs, exp_out((outs < BLK) ? 20 : 400, outs % BLK));
        end
        outs++;
      end
      if (in_valid && in_ready) begin
        if (acc == 2 * BS - 1) t_b = cyc;
        acc++;
      end
      @(posedge clk); #1;
      if (acc < BS) begin
        in_valid = 1'b1;
        set_pixel(20, acc);
      end else if (acc < 2 * BS && outs >= 2 * BS) begin
        in_valid = 1'b1;
        set_pixel(400, acc - BS);
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (t_b < 0 || t_last != t_b) begin
      failures++;
      $display("FAIL simul_align: got last_cr=%0d last_write=%0d expected equal", t_last, t_b);
    end
    checks++;
    if (gap_valid !== 1'b0 || gap_ready !== 1'b1) begin
      failures++;
      $display("FAIL simul_flags: got valid=%b ready=%b expected 0/1", gap_valid, gap_ready);
    end
    checks++;
    if (first_b != t_b + 2) begin
      failures++;
      $display("FAIL simul_start: got cycle %0d expected %0d", first_b, t_b + 2);
    end
  endtask

  task automatic test_async_reset();
    int acc = 0, outs = 0;
    bit hit = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_pixel(0, 0);
    for (int cyc = 0; cyc < 600 && !hit; cyc++) begin
      @(negedge clk);
      if (out_valid && outs == BS + 30) begin
        hit = 1'b1;
      end else begin
        if (out_valid) outs++;
        if (in_valid && in_ready) acc++;
        @(posedge clk); #1;
        if (acc < BS + 10) begin
          in_valid = 1'b1;
          set_pixel((acc < BS) ? 0 : 700, acc % BS);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checks++;
    if (!hit || obs !== exp_out(0, BS + 30)) begin
      failures++;
      $display("FAIL areset_reach_cb30: got hit=%b obs=%h expected 1/%h", hit, obs, exp_out(0, BS + 30));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs} !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL areset_outputs: got valid=%b obs=%h ready=%b expected 0/0/1", out_valid, obs, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_block(0);
    test_backpressure_fill();
    test_output_stall();
    test_simultaneous();
    test_async_reset();
    test_single_block(500);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
